// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status inputs and stall/flush controls.
// The master side (pipeline / bench) drives the status signals.
// The slave side (the hazard controller) drives the controls.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        idex_memRead;
  logic [4:0]  idex_rd;
  logic        ex_br_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_bubble;
  logic        mem_timeout;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, idex_memRead, idex_rd, ex_br_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           memwb_bubble, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, idex_memRead, idex_rd, ex_br_taken, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           memwb_bubble, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for a 5-stage RV32I pipeline.
// It handles load-use bubbles, taken-branch flushes and data-memory waits.
// The controls are Mealy: a function of the FSM state and the current inputs.
// While rst_n is low the controls are forced to the safe value:
// all enables off, with every flush and the bubble asserted.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_TO     = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic mw_s, br_s, lu_s, release_s;
  logic pc_en_s, ifid_en_s, idex_en_s, exmem_en_s;
  logic ifid_flush_s, idex_flush_s, memwb_bubble_s, mem_timeout_s;

  // Hazard condition terms. The priority order is MW > BR > LU.
  always_comb begin
    mw_s      = hz.mem_req & ~hz.mem_ready;
    br_s      = hz.ex_br_taken;
    lu_s      = hz.idex_memRead & (hz.idex_rd != 5'd0) &
                ((hz.idex_rd == hz.id_rs1) | (hz.idex_rd == hz.id_rs2));
    // A request that drops without ready also ends the wait.
    release_s = hz.mem_ready | ~hz.mem_req;
  end

  // Next-state, counter and Mealy control outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_en_s        = 1'b1;
    ifid_en_s      = 1'b1;
    idex_en_s      = 1'b1;
    exmem_en_s     = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_flush_s   = 1'b0;
    memwb_bubble_s = 1'b0;
    mem_timeout_s  = 1'b0;
    if (!rst_n) begin
      pc_en_s        = 1'b0;
      ifid_en_s      = 1'b0;
      idex_en_s      = 1'b0;
      exmem_en_s     = 1'b0;
      ifid_flush_s   = 1'b1;
      idex_flush_s   = 1'b1;
      memwb_bubble_s = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if ((state_q == ST_RUN) ? mw_s : !release_s) begin
            // Freeze the whole pipe and drain a bubble into WB.
            pc_en_s        = 1'b0;
            ifid_en_s      = 1'b0;
            idex_en_s      = 1'b0;
            exmem_en_s     = 1'b0;
            memwb_bubble_s = 1'b1;
            if (state_q == ST_RUN) begin
              state_d = ST_MEM_WAIT;
              cnt_d   = CNT_ONE;
            end else if (cnt_q == MEM_TO) begin
              state_d = ST_FAULT;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            // A run cycle, including the wait-release cycle.
            // EX was held during the freeze, so a branch or load-use
            // hazard that was pending is handled here.
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
            if (br_s) begin
              ifid_flush_s = 1'b1;
              idex_flush_s = 1'b1;
              if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_INIT;
              end else begin
                state_d = ST_RUN;
              end
            end else if (lu_s) begin
              pc_en_s      = 1'b0;
              ifid_en_s    = 1'b0;
              idex_flush_s = 1'b1;
            end else begin
              pc_en_s = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          ifid_flush_s = 1'b1;
          if (mw_s) begin
            // The freeze wins. The rest of the flush is dropped,
            // but IF/ID keeps loading NOPs during this cycle.
            pc_en_s        = 1'b0;
            ifid_en_s      = 1'b0;
            idex_en_s      = 1'b0;
            exmem_en_s     = 1'b0;
            memwb_bubble_s = 1'b1;
            state_d        = ST_MEM_WAIT;
            cnt_d          = CNT_ONE;
          end else begin
            if (lu_s) begin
              pc_en_s      = 1'b0;
              ifid_en_s    = 1'b0;
              idex_flush_s = 1'b1;
            end else begin
              pc_en_s = 1'b1;
            end
            if (cnt_q == CNT_ONE) begin
              state_d = ST_RUN;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        ST_FAULT: begin
          pc_en_s        = 1'b0;
          ifid_en_s      = 1'b0;
          idex_en_s      = 1'b0;
          exmem_en_s     = 1'b0;
          memwb_bubble_s = 1'b1;
          mem_timeout_s  = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    if (!pc_en_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, counter and stall-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= CNT_ZERO;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_en        = pc_en_s;
  assign hz.ifid_en      = ifid_en_s;
  assign hz.idex_en      = idex_en_s;
  assign hz.exmem_en     = exmem_en_s;
  assign hz.ifid_flush   = ifid_flush_s;
  assign hz.idex_flush   = idex_flush_s;
  assign hz.memwb_bubble = memwb_bubble_s;
  assign hz.mem_timeout  = mem_timeout_s;
  assign hz.stall_cnt    = stall_cnt_q;

endmodule
